// File: rtl/icon_reg_sync.sv
// Frame-synchronous update controller for the Rojobot icon overlay.
// Bot updates are captured into a shadow set. The shadow is committed to the display registers only at vertical blank, so the icon never tears mid-frame.
// Ports: clock/rst (synchronous, active-high); upd_sysregs + LocX_in/LocY_in/BotInfo_in (bot update strobe and data).
//        Pixel_row/Pixel_column (DTG position); LocX_reg/LocY_reg/BotInfo_reg (committed values); upd_ack (commit pulse).
//        overrun_cnt (saturating count of lost updates); blink_on (icon draw enable).
// Latency: tick in PENDING at cycle N -> COMMIT at N+1 -> display regs valid at N+2. No backpressure is applied.
module icon_reg_sync #(
  parameter int          V_ACTIVE     = 480,
  parameter int          BLINK_FRAMES = 15,
  parameter logic [7:0]  BLINK_MASK   = 8'hF0,
  parameter logic [7:0]  RST_X        = 8'd0,
  parameter logic [7:0]  RST_Y        = 8'd0
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       upd_sysregs,
  input  logic [7:0] LocX_in,
  input  logic [7:0] LocY_in,
  input  logic [7:0] BotInfo_in,
  input  logic [9:0] Pixel_row,
  input  logic [9:0] Pixel_column,
  output logic [7:0] LocX_reg,
  output logic [7:0] LocY_reg,
  output logic [7:0] BotInfo_reg,
  output logic       upd_ack,
  output logic [7:0] overrun_cnt,
  output logic       blink_on
);

  localparam logic [9:0] TICK_ROW   = V_ACTIVE[9:0];
  localparam logic [7:0] LAST_FRAME = 8'(BLINK_FRAMES - 1);

  typedef enum logic [1:0] {IDLE, PENDING, COMMIT} state_t;

  state_t     state;
  logic [7:0] shadow_x;
  logic [7:0] shadow_y;
  logic [7:0] shadow_info;
  logic       hit;
  logic       hit_q;
  logic       tick;
  logic [7:0] frame_cnt;
  logic       blink_en;

  // The DTG may dwell on the tick position for several clocks.
  // The tick is therefore taken as the rising edge of the position match,
  // which gives one tick per frame.
  assign hit      = (Pixel_row == TICK_ROW) && (Pixel_column == 10'd0);
  assign tick     = hit && !hit_q;
  assign blink_en = (BotInfo_reg & BLINK_MASK) != 8'd0;

  always_ff @(posedge clock) begin
    if (rst) begin
      hit_q <= 1'b0;
    end else begin
      hit_q <= hit;
    end
  end

  // Update FSM. The display registers are written only in COMMIT.
  always_ff @(posedge clock) begin
    if (rst) begin
      state       <= IDLE;
      shadow_x    <= 8'd0;
      shadow_y    <= 8'd0;
      shadow_info <= 8'd0;
      LocX_reg    <= RST_X;
      LocY_reg    <= RST_Y;
      BotInfo_reg <= 8'd0;
      upd_ack     <= 1'b0;
      overrun_cnt <= 8'd0;
    end else begin
      upd_ack <= 1'b0;
      case (state)
        IDLE: begin
          // A tick seen here has nothing to commit yet.
          // Data arriving with that tick waits for the next frame.
          if (upd_sysregs) begin
            shadow_x    <= LocX_in;
            shadow_y    <= LocY_in;
            shadow_info <= BotInfo_in;
            state       <= PENDING;
          end
        end
        PENDING: begin
          if (upd_sysregs) begin
            shadow_x    <= LocX_in;
            shadow_y    <= LocY_in;
            shadow_info <= BotInfo_in;
            if (overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'd1;
          end
          if (tick) begin
            // upd_ack is registered, so it is high during the COMMIT cycle itself.
            state   <= COMMIT;
            upd_ack <= 1'b1;
          end
        end
        COMMIT: begin
          // The copy reads the shadow before any same-cycle reload.
          // The old shadow is committed, and new data waits for the next frame.
          LocX_reg    <= shadow_x;
          LocY_reg    <= shadow_y;
          BotInfo_reg <= shadow_info;
          if (upd_sysregs) begin
            shadow_x    <= LocX_in;
            shadow_y    <= LocY_in;
            shadow_info <= BotInfo_in;
            state       <= PENDING;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Blink generator. While blinking is disabled, the counter is parked at 0 with blink_on high.
  // Re-enabling therefore always starts a full visible half-period.
  always_ff @(posedge clock) begin
    if (rst) begin
      frame_cnt <= 8'd0;
      blink_on  <= 1'b1;
    end else if (!blink_en) begin
      frame_cnt <= 8'd0;
      blink_on  <= 1'b1;
    end else if (tick) begin
      if (frame_cnt == LAST_FRAME) begin
        frame_cnt <= 8'd0;
        blink_on  <= !blink_on;
      end else begin
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_icon_reg_sync.sv
module tb_icon_reg_sync;

  localparam logic [7:0] RX = 8'h05;
  localparam logic [7:0] RY = 8'h07;

  logic       clock = 1'b0;
  logic       rst;
  logic       upd_sysregs;
  logic [7:0] LocX_in, LocY_in, BotInfo_in;
  logic [9:0] Pixel_row, Pixel_column;
  logic [7:0] LocX_reg, LocY_reg, BotInfo_reg;
  logic       upd_ack;
  logic [7:0] overrun_cnt;
  logic       blink_on;

  int checks = 0;
  int errors = 0;

  icon_reg_sync #(
    .V_ACTIVE(480), .BLINK_FRAMES(15), .BLINK_MASK(8'hF0), .RST_X(RX), .RST_Y(RY)
  ) dut (
    .clock(clock), .rst(rst), .upd_sysregs(upd_sysregs),
    .LocX_in(LocX_in), .LocY_in(LocY_in), .BotInfo_in(BotInfo_in),
    .Pixel_row(Pixel_row), .Pixel_column(Pixel_column),
    .LocX_reg(LocX_reg), .LocY_reg(LocY_reg), .BotInfo_reg(BotInfo_reg),
    .upd_ack(upd_ack), .overrun_cnt(overrun_cnt), .blink_on(blink_on)
  );

  always #20 clock = ~clock;

  typedef struct {
    logic       upd;
    logic       tick;
    logic [7:0] x, y, b;
    logic [7:0] ex, ey, eb;
    logic       ack;
    logic [7:0] ovr;
    logic       blink;
  } vec_t;

  vec_t vt[23];

  function automatic vec_t mk(logic upd, logic tick, logic [7:0] x, logic [7:0] y, logic [7:0] b,
                              logic [7:0] ex, logic [7:0] ey, logic [7:0] eb,
                              logic ack, logic [7:0] ovr, logic blink);
    vec_t v;
    v.upd = upd; v.tick = tick; v.x = x; v.y = y; v.b = b;
    v.ex = ex; v.ey = ey; v.eb = eb; v.ack = ack; v.ovr = ovr; v.blink = blink;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_pos(input logic at_tick);
    if (at_tick) begin Pixel_row = 10'd480; Pixel_column = 10'd0; end
    else begin Pixel_row = 10'd100; Pixel_column = 10'd5; end
  endtask

  task automatic strobe(input logic [7:0] x, input logic [7:0] y, input logic [7:0] b);
    upd_sysregs = 1'b1; LocX_in = x; LocY_in = y; BotInfo_in = b;
    step();
    upd_sysregs = 1'b0;
  endtask

  // One tick cycle followed by one ordinary cycle.
  task automatic frame_tick();
    set_pos(1'b1);
    step();
    set_pos(1'b0);
    step();
  endtask

  initial begin
    int acks;
    rst = 1'b1; upd_sysregs = 1'b0; LocX_in = 8'd0; LocY_in = 8'd0; BotInfo_in = 8'd0;
    set_pos(1'b0);
    step(); step();
    rst = 1'b0;
    check("rst_x", LocX_reg, RX);
    check("rst_y", LocY_reg, RY);
    check("rst_info", BotInfo_reg, 8'h00);
    check("rst_ack", upd_ack, 1'b0);
    check("rst_ovr", overrun_cnt, 8'h00);
    check("rst_blink", blink_on, 1'b1);

    //            upd tick x      y      b      ex     ey     eb     ack ovr    blink
    vt[0]  = mk(1, 0, 8'h20, 8'h30, 8'h00, RX,    RY,    8'h00, 0, 8'd0, 1); // basic update
    vt[1]  = mk(0, 0, 8'h00, 8'h00, 8'h00, RX,    RY,    8'h00, 0, 8'd0, 1);
    vt[2]  = mk(0, 1, 8'h00, 8'h00, 8'h00, RX,    RY,    8'h00, 1, 8'd0, 1); // COMMIT cycle
    vt[3]  = mk(0, 0, 8'h00, 8'h00, 8'h00, 8'h20, 8'h30, 8'h00, 0, 8'd0, 1); // visible N+2
    vt[4]  = mk(0, 0, 8'h00, 8'h00, 8'h00, 8'h20, 8'h30, 8'h00, 0, 8'd0, 1);
    vt[5]  = mk(1, 0, 8'h01, 8'h00, 8'h00, 8'h20, 8'h30, 8'h00, 0, 8'd0, 1); // three strobes
    vt[6]  = mk(1, 0, 8'h02, 8'h00, 8'h00, 8'h20, 8'h30, 8'h00, 0, 8'd1, 1);
    vt[7]  = mk(1, 0, 8'h03, 8'h00, 8'h00, 8'h20, 8'h30, 8'h00, 0, 8'd2, 1);
    vt[8]  = mk(0, 1, 8'h00, 8'h00, 8'h00, 8'h20, 8'h30, 8'h00, 1, 8'd2, 1);
    vt[9]  = mk(0, 0, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 0, 8'd2, 1);
    vt[10] = mk(1, 1, 8'h09, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 0, 8'd2, 1); // strobe+tick from IDLE
    vt[11] = mk(0, 0, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 0, 8'd2, 1);
    vt[12] = mk(0, 1, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 1, 8'd2, 1);
    vt[13] = mk(0, 0, 8'h00, 8'h00, 8'h00, 8'h09, 8'h00, 8'h00, 0, 8'd2, 1);
    vt[14] = mk(1, 0, 8'h04, 8'h00, 8'h00, 8'h09, 8'h00, 8'h00, 0, 8'd2, 1); // strobe+tick from PENDING
    vt[15] = mk(1, 1, 8'h0A, 8'h00, 8'h00, 8'h09, 8'h00, 8'h00, 1, 8'd3, 1);
    vt[16] = mk(0, 0, 8'h00, 8'h00, 8'h00, 8'h0A, 8'h00, 8'h00, 0, 8'd3, 1);
    vt[17] = mk(1, 0, 8'h40, 8'h00, 8'h00, 8'h0A, 8'h00, 8'h00, 0, 8'd3, 1); // strobe during COMMIT
    vt[18] = mk(0, 1, 8'h00, 8'h00, 8'h00, 8'h0A, 8'h00, 8'h00, 1, 8'd3, 1);
    vt[19] = mk(1, 0, 8'h41, 8'h00, 8'h00, 8'h40, 8'h00, 8'h00, 0, 8'd3, 1);
    vt[20] = mk(0, 0, 8'h00, 8'h00, 8'h00, 8'h40, 8'h00, 8'h00, 0, 8'd3, 1);
    vt[21] = mk(0, 1, 8'h00, 8'h00, 8'h00, 8'h40, 8'h00, 8'h00, 1, 8'd3, 1);
    vt[22] = mk(0, 0, 8'h00, 8'h00, 8'h00, 8'h41, 8'h00, 8'h00, 0, 8'd3, 1);

    for (int i = 0; i < 23; i++) begin
      upd_sysregs = vt[i].upd; LocX_in = vt[i].x; LocY_in = vt[i].y; BotInfo_in = vt[i].b;
      set_pos(vt[i].tick);
      step();
      upd_sysregs = 1'b0;
      set_pos(1'b0);
      check($sformatf("vec%0d_x", i), LocX_reg, vt[i].ex);
      check($sformatf("vec%0d_y", i), LocY_reg, vt[i].ey);
      check($sformatf("vec%0d_info", i), BotInfo_reg, vt[i].eb);
      check($sformatf("vec%0d_ack", i), upd_ack, vt[i].ack);
      check($sformatf("vec%0d_ovr", i), overrun_cnt, vt[i].ovr);
      check($sformatf("vec%0d_blink", i), blink_on, vt[i].blink);
    end

    // Tick position held for 5 clocks gives a single commit.
    strobe(8'h50, 8'h00, 8'h00);
    acks = 0;
    set_pos(1'b1);
    for (int i = 0; i < 5; i++) begin step(); if (upd_ack) acks++; end
    set_pos(1'b0);
    for (int i = 0; i < 2; i++) begin step(); if (upd_ack) acks++; end
    check("hold_ack_count", acks, 1);
    check("hold_x", LocX_reg, 8'h50);

    // Overrun saturation. The first strobe from IDLE loads the shadow and is not counted.
    for (int i = 0; i < 10; i++) strobe(8'h60, 8'h00, 8'h00);
    check("ovr_mid", overrun_cnt, 8'd12);
    for (int i = 0; i < 290; i++) strobe(8'h61, 8'h00, 8'h00);
    check("ovr_sat", overrun_cnt, 8'd255);
    frame_tick();
    check("ovr_sat_x", LocX_reg, 8'h61);
    check("ovr_hold", overrun_cnt, 8'd255);

    // Blinking with BotInfo = 0x10.
    strobe(8'h00, 8'h00, 8'h10);
    frame_tick();
    check("blink_info", BotInfo_reg, 8'h10);
    check("blink_start", blink_on, 1'b1);
    for (int k = 1; k <= 20; k++) begin
      frame_tick();
      check($sformatf("blink_k%0d", k), blink_on, ((k / 15) % 2) == 0);
    end
    // Disable with BotInfo = 0x03. blink_on is forced high and stays high.
    strobe(8'h00, 8'h00, 8'h03);
    frame_tick();
    step();
    check("blink_off_info", BotInfo_reg, 8'h03);
    check("blink_forced", blink_on, 1'b1);
    for (int k = 1; k <= 20; k++) frame_tick();
    check("blink_forced_hold", blink_on, 1'b1);
    // Re-enable with BotInfo = 0x80. Blinking restarts with a full visible half-period.
    strobe(8'h00, 8'h00, 8'h80);
    frame_tick();
    check("blink_reen_info", BotInfo_reg, 8'h80);
    for (int k = 1; k <= 16; k++) begin
      frame_tick();
      check($sformatf("blink_re_k%0d", k), blink_on, k < 15);
    end

    // A reset while an update is pending drops that update.
    strobe(8'h77, 8'h00, 8'h00);
    rst = 1'b1; step(); rst = 1'b0;
    set_pos(1'b1); step(); set_pos(1'b0);
    check("rstpend_ack", upd_ack, 1'b0);
    step();
    check("rstpend_x", LocX_reg, RX);
    check("rstpend_y", LocY_reg, RY);
    check("rstpend_ovr", overrun_cnt, 8'd0);
    check("rstpend_blink", blink_on, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
